// File: rtl/mp_regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_DEPTH = 5;

endpackage

// File: rtl/mp_regfile_if.sv
// Read/write/clear bus of the register file; master drives requests, slave returns data.
interface mp_regfile_if
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int DEPTH = RF_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) ();

    logic [NRD-1:0][DEPTH-1:0] rs_addr;
    logic [NRD-1:0][XLEN-1:0]  rs_data;
    logic [NWR-1:0]            rd_we;
    logic [NWR-1:0][DEPTH-1:0] rd_addr;
    logic [NWR-1:0][XLEN-1:0]  rd_data;
    logic                      clear_req;
    logic                      ready;

    modport master (
        output rs_addr, rd_we, rd_addr, rd_data, clear_req,
        input  rs_data, ready
    );

    modport slave (
        input  rs_addr, rd_we, rd_addr, rd_data, clear_req,
        output rs_data, ready
    );

endinterface

// File: rtl/mp_regfile_clear_seq.sv
// Clear sequencer: sweeps zeros through every entry after reset or on request,
// then holds READY until the next clear request.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_req_i,
    output logic             ready_o,
    output logic             clr_we_o,
    output logic [DEPTH-1:0] clr_addr_o
);

    // One extra bit keeps the terminal count distinct from entry 0.
    localparam logic [DEPTH:0] LAST_ENTRY = (DEPTH+1)'(2**DEPTH - 1);

    rf_state_t      state_q, state_d;
    logic [DEPTH:0] count_q, count_d;
    logic           ready_q, ready_d;

    // State, sweep counter and registered ready flag; reset restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: CLEAR zeroes one entry per cycle, READY waits for clear_req.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ready_d    = ready_q;
        clr_we_o   = 1'b0;
        clr_addr_o = count_q[DEPTH-1:0];
        case (state_q)
            CLEAR: begin
                clr_we_o = 1'b1;
                ready_d  = 1'b0;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_ENTRY) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
            end
            READY: begin
                ready_d = 1'b1;
                if (clear_req_i) begin
                    state_d = CLEAR;
                    count_d = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
                count_d = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file with registered reads, optional write-first bypass,
// hardwired-zero entry 0 and a hardware clear sweep instead of a storage reset.
module mp_regfile
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mp_regfile_if.slave bus
);

    logic [XLEN-1:0]           mem [2**DEPTH];
    logic [NRD-1:0][XLEN-1:0]  rsData_q, rsData_d;
    logic [NWR-1:0]            writeEn;
    logic                      ready;
    logic                      clrWe;
    logic [DEPTH-1:0]          clrAddr;
    logic                      accept;

    rf_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req_i (bus.clear_req),
        .ready_o     (ready),
        .clr_we_o    (clrWe),
        .clr_addr_o  (clrAddr)
    );

    // A cycle that requests a clear drops its writes and reads back zero.
    assign accept = ready && !bus.clear_req;

    // Effective write enables; writes to the hardwired-zero entry are discarded.
    always_comb begin
        writeEn = '0;
        for (int w = 0; w < NWR; w++) begin
            writeEn[w] = bus.rd_we[w] && accept &&
                         !((ZERO_REG != 0) && (bus.rd_addr[w] == '0));
        end
    end

    // Storage has no reset; later ports are written last so port 1 wins a conflict.
    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end
        for (int w = 0; w < NWR; w++) begin
            if (writeEn[w]) begin
                mem[bus.rd_addr[w]] <= bus.rd_data[w];
            end
        end
    end

    // Read data selection: array, then same-cycle write bypass, then zero overrides.
    always_comb begin
        rsData_d = '0;
        for (int i = 0; i < NRD; i++) begin
            rsData_d[i] = mem[bus.rs_addr[i]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (writeEn[w] && (bus.rd_addr[w] == bus.rs_addr[i])) begin
                        rsData_d[i] = bus.rd_data[w];
                    end
                end
            end
            if ((ZERO_REG != 0) && (bus.rs_addr[i] == '0)) begin
                rsData_d[i] = '0;
            end
            if (!accept) begin
                rsData_d[i] = '0;
            end
        end
    end

    // Registered read ports, forced to zero immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsData_q <= '0;
        end else begin
            rsData_q <= rsData_d;
        end
    end

    assign bus.rs_data = rsData_q;
    assign bus.ready   = ready;

endmodule

// File: tb/tb_mp_regfile.sv
// Scoreboard bench: a write-first single-write file (A) and a read-first
// dual-write file (B) run the same traffic side by side.
module tb_mp_regfile;

    logic clk;
    logic rst_n;

    mp_regfile_if #(.XLEN(32), .DEPTH(5), .NRD(2), .NWR(1)) ifA ();
    mp_regfile_if #(.XLEN(32), .DEPTH(5), .NRD(2), .NWR(2)) ifB ();

    mp_regfile #(.XLEN(32), .DEPTH(5), .NRD(2), .NWR(1), .ZERO_REG(1), .BYPASS(1)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    mp_regfile #(.XLEN(32), .DEPTH(5), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
        int          sel;
    } sbEntry_t;

    sbEntry_t    scoreboard[$];
    logic [31:0] modelA [32];
    logic [31:0] modelB [32];
    int          compared;
    int          mismatched;

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drop all write and clear requests.
    task automatic idleBus();
        ifA.rd_we     = '0;
        ifB.rd_we     = '0;
        ifA.clear_req = 1'b0;
        ifB.clear_req = 1'b0;
    endtask

    // One cycle of traffic: port-0 write goes to both files, port-1 write only to B.
    task automatic applyStimulus(input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic clr);
        sbEntry_t    e;
        logic [4:0]  ra [2];
        logic [31:0] expA;
        logic [31:0] expB;
        ra[0] = ra0;
        ra[1] = ra1;
        ifA.rs_addr   = {ra1, ra0};
        ifB.rs_addr   = {ra1, ra0};
        ifA.rd_we     = we0;
        ifA.rd_addr   = wa0;
        ifA.rd_data   = wd0;
        ifB.rd_we     = {we1, we0};
        ifB.rd_addr   = {wa1, wa0};
        ifB.rd_data   = {wd1, wd0};
        ifA.clear_req = clr;
        ifB.clear_req = clr;
        for (int p = 0; p < 2; p++) begin
            if (clr || ra[p] == 5'd0) begin
                expA = 32'h0;
                expB = 32'h0;
            end else begin
                expA = (we0 && wa0 == ra[p]) ? wd0 : modelA[ra[p]];
                expB = modelB[ra[p]];
            end
            e.tag = $sformatf("A.rs%0d[x%0d]", p, ra[p]); e.value = expA; e.sel = p;
            scoreboard.push_back(e);
            e.tag = $sformatf("B.rs%0d[x%0d]", p, ra[p]); e.value = expB; e.sel = 2 + p;
            scoreboard.push_back(e);
        end
        @(posedge clk);
        if (!clr) begin
            if (we0 && wa0 != 5'd0) begin
                modelA[wa0] = wd0;
                modelB[wa0] = wd0;
            end
            if (we1 && wa1 != 5'd0) modelB[wa1] = wd1;
        end
        #1;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            case (e.sel)
                0:       checkOutput(e.tag, ifA.rs_data[0], e.value);
                1:       checkOutput(e.tag, ifA.rs_data[1], e.value);
                2:       checkOutput(e.tag, ifB.rs_data[0], e.value);
                default: checkOutput(e.tag, ifB.rs_data[1], e.value);
            endcase
        end
        checkOutput("A.ready", {31'b0, ifA.ready}, {31'b0, !clr});
        checkOutput("B.ready", {31'b0, ifB.ready}, {31'b0, !clr});
    endtask

    // Count edges until ready returns; outputs must stay zero meanwhile.
    task automatic waitReady(input string tag, input int expCycles);
        int   n;
        logic allZero;
        idleBus();
        n       = 0;
        allZero = 1'b1;
        while (ifA.ready !== 1'b1 && n < 200) begin
            if (ifA.rs_data != '0 || ifB.rs_data != '0 || ifA.ready || ifB.ready) allZero = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, ".cycles"}, 32'(n), 32'(expCycles));
        checkOutput({tag, ".zeroWhileClear"}, {31'b0, allZero}, 32'h1);
        checkOutput({tag, ".B.ready"}, {31'b0, ifB.ready}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            modelA[i] = 32'h0;
            modelB[i] = 32'h0;
        end
    endtask

    // Read every entry, two per cycle.
    task automatic readAll();
        for (int i = 0; i < 32; i += 2) begin
            applyStimulus(5'(i), 5'(i + 1), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        end
    endtask

    // Write x1..x31 with distinct patterns through port 0.
    task automatic fillAll(input logic [31:0] base);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(5'(i), 5'(i - 1), 1'b1, 5'(i), base + 32'(i) * 32'h111,
                          1'b0, 5'd0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        ifA.rs_addr = '0;
        ifB.rs_addr = '0;
        ifA.rd_addr = '0;
        ifB.rd_addr = '0;
        ifA.rd_data = '0;
        ifB.rd_data = '0;
        idleBus();
        for (int i = 0; i < 32; i++) begin
            modelA[i] = 32'h0;
            modelB[i] = 32'h0;
        end

        #12;
        checkOutput("reset.A.rs_data", ifA.rs_data[0] | ifA.rs_data[1], 32'h0);
        checkOutput("reset.B.rs_data", ifB.rs_data[0] | ifB.rs_data[1], 32'h0);
        checkOutput("reset.A.ready", {31'b0, ifA.ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitReady("initClear", 32);
        readAll();

        fillAll(32'h1000_0000);
        readAll();

        // Write-first on A, read-first on B, then both see the new value.
        applyStimulus(5'd5, 5'd6, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
        applyStimulus(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Entry 0 stays zero through a write and its bypass window.
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b0);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Same-address dual write on B: port 1 must win.
        applyStimulus(5'd7, 5'd7, 1'b1, 5'd7, 32'h0000_AAAA, 1'b1, 5'd7, 32'h0000_5555, 1'b0);
        applyStimulus(5'd7, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Mixed random traffic, including random port-1 writes on B.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'b0);
        end

        // Soft clear with a write to x3 in the same cycle; the write is dropped.
        fillAll(32'h2000_0000);
        applyStimulus(5'd3, 5'd4, 1'b1, 5'd3, 32'h0000_CAFE, 1'b0, 5'd0, 32'h0, 1'b1);
        waitReady("softClear", 32);
        readAll();
        applyStimulus(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Reset during normal operation clears outputs without waiting for a clock.
        fillAll(32'h3000_0000);
        applyStimulus(5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstAsync.A.rs0", ifA.rs_data[0], 32'h0);
        checkOutput("rstAsync.B.rs1", ifB.rs_data[1], 32'h0);
        checkOutput("rstAsync.A.ready", {31'b0, ifA.ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitReady("rstReady", 32);
        readAll();

        // Reset at sweep counter 10 must restart the full sweep.
        fillAll(32'h4000_0000);
        applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        idleBus();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstSweep.A.rs_data", ifA.rs_data[0] | ifA.rs_data[1], 32'h0);
        checkOutput("rstSweep.B.ready", {31'b0, ifB.ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitReady("rstSweepReady", 32);
        readAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
